// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants for the pipeline control unit.
//   STG_*          stage index names for the default five-stage core
//   DEFAULT_STAGES default pipeline depth
//   DEFAULT_CNT_W  default width of the performance counters
package pipe_ctrl_pkg;

    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

    localparam int unsigned DEFAULT_STAGES = 5;
    localparam int unsigned DEFAULT_CNT_W  = 64;

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the pipeline stages and the control unit.
//   stall_req    per-stage "cannot complete" requests
//   flush_req    branch redirect from the flush stage
//   fetch_valid  fetch unit presents a real instruction
//   halt         global freeze
//   ena          per-stage load enables (combinational)
//   valid        per-stage valid bits (registered)
//   retire       last stage completes this cycle
//   stall_cycles / retired  performance counters
// Modports: master = stage side, slave = control unit.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STAGES = DEFAULT_STAGES,
    parameter int unsigned CNT_W  = DEFAULT_CNT_W
);

    logic [STAGES-1:0] stall_req;
    logic              flush_req;
    logic              fetch_valid;
    logic              halt;
    logic [STAGES-1:0] ena;
    logic [STAGES-1:0] valid;
    logic              retire;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  retired;

    modport master (
        output stall_req, flush_req, fetch_valid, halt,
        input  ena, valid, retire, stall_cycles, retired
    );

    modport slave (
        input  stall_req, flush_req, fetch_valid, halt,
        output ena, valid, retire, stall_cycles, retired
    );

endinterface

// File: rtl/pipe_ctrl_prio.sv
// pipe_ctrl_prio: highest-set-bit priority encoder.
//   i_req    request vector
//   o_idx    index of the highest set bit (0 when none set)
//   o_found  at least one request bit is set
module pipe_ctrl_prio #(
    parameter int unsigned WIDTH = 5,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Ascending scan: the last hit wins, giving the highest index.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i_req[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/valid/flush controller with perf counters.
//   clk      clock
//   rst      synchronous active-high reset
//   io_pipe  slave side of pipe_ctrl_if (requests in; ena, valid, retire,
//            stall_cycles, retired out)
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STAGES      = DEFAULT_STAGES,
    parameter int unsigned FLUSH_STAGE = 1,
    parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave io_pipe
);

    localparam int unsigned IDX_W = $clog2(STAGES);

    logic [STAGES-1:0] r_valid;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [CNT_W-1:0]  r_retired;

    logic [STAGES-1:0] w_low_mask;
    logic [STAGES-1:0] w_stall_eff;
    logic [STAGES-1:0] w_prev;
    logic [STAGES-1:0] w_valid_d;
    logic [STAGES-1:0] w_ena;
    logic              w_hi_stall;
    logic              w_flush_eff;
    logic              w_found;
    logic              w_retire;
    logic [IDX_W-1:0]  w_hold;
    int                w_hold_i;

    // A flush is only honoured when nothing at or past the branch stage
    // stalls; an honoured flush discards stalls from the wrong-path stages.
    always_comb begin
        w_low_mask = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            w_low_mask[i] = (i < int'(FLUSH_STAGE));
        end
        w_hi_stall  = |(io_pipe.stall_req & ~w_low_mask);
        w_flush_eff = io_pipe.flush_req & ~w_hi_stall;
        w_stall_eff = w_flush_eff ? (io_pipe.stall_req & ~w_low_mask) : io_pipe.stall_req;
    end

    pipe_ctrl_prio #(
        .WIDTH (STAGES)
    ) u_prio (
        .i_req   (w_stall_eff),
        .o_idx   (w_hold),
        .o_found (w_found)
    );

    // -1 encodes "no effective stall".
    always_comb begin
        w_hold_i = w_found ? int'(w_hold) : -1;
    end

    always_comb begin
        w_ena = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            w_ena[i] = !rst && !io_pipe.halt && (i > w_hold_i);
        end
        w_retire = !rst && !io_pipe.halt && r_valid[STAGES-1] &&
                   (w_hold_i != int'(STAGES) - 1);
    end

    // w_prev[i] is what stage i would load when advancing normally.
    always_comb begin
        w_prev    = {r_valid[STAGES-2:0], io_pipe.fetch_valid};
        w_valid_d = r_valid;
        for (int i = 0; i < int'(STAGES); i++) begin
            if (i <= w_hold_i) begin
                w_valid_d[i] = r_valid[i];
            end else if (i == w_hold_i + 1 && i >= 1) begin
                w_valid_d[i] = 1'b0;
            end else if (w_flush_eff && i >= 1 && i <= int'(FLUSH_STAGE)) begin
                w_valid_d[i] = 1'b0;
            end else begin
                w_valid_d[i] = w_prev[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid        <= '0;
            r_stall_cycles <= '0;
            r_retired      <= '0;
        end else if (!io_pipe.halt) begin
            r_valid <= w_valid_d;
            if (w_found) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign io_pipe.ena          = w_ena;
    assign io_pipe.retire       = w_retire;
    assign io_pipe.valid        = r_valid;
    assign io_pipe.stall_cycles = r_stall_cycles;
    assign io_pipe.retired      = r_retired;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
//   u_dut_a  default 5-stage, 64-bit counters
//   u_dut_b  5-stage, 4-bit counters for the wrap check
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.STAGES(5), .CNT_W(64)) bus_a ();
    pipe_ctrl_if #(.STAGES(5), .CNT_W(4))  bus_b ();

    pipe_ctrl #(
        .STAGES      (5),
        .FLUSH_STAGE (1),
        .CNT_W       (64)
    ) u_dut_a (
        .clk     (clk),
        .rst     (rst_a),
        .io_pipe (bus_a.slave)
    );

    pipe_ctrl #(
        .STAGES      (5),
        .FLUSH_STAGE (1),
        .CNT_W       (4)
    ) u_dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .io_pipe (bus_b.slave)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a             = 1'b1;
        rst_b             = 1'b1;
        bus_a.stall_req   = '0;
        bus_a.flush_req   = 1'b0;
        bus_a.fetch_valid = 1'b1;
        bus_a.halt        = 1'b0;
        bus_b.stall_req   = '0;
        bus_b.flush_req   = 1'b0;
        bus_b.fetch_valid = 1'b1;
        bus_b.halt        = 1'b0;

        // Reset state
        tick();
        check_val("rst_valid", 64'(bus_a.valid), 64'h0);
        check_val("rst_ena", 64'(bus_a.ena), 64'h0);
        check_val("rst_retire", 64'(bus_a.retire), 64'h0);
        check_val("rst_stall_cnt", bus_a.stall_cycles, 64'h0);
        check_val("rst_retired", bus_a.retired, 64'h0);
        rst_a = 1'b0;
        #1;
        check_val("post_rst_ena", 64'(bus_a.ena), 64'h1f);

        // Fill
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_val($sformatf("fill_valid_%0d", k), 64'(bus_a.valid), 64'((1 << k) - 1));
        end
        check_val("fill_retire", 64'(bus_a.retire), 64'h1);
        tick();
        tick();
        tick();
        check_val("fill_retired3", bus_a.retired, 64'd3);

        // Single EX stall for two cycles on a full pipe
        bus_a.stall_req = 5'b00100;
        #1;
        check_val("ex_stall_ena1", 64'(bus_a.ena), 64'h18);
        tick();
        check_val("ex_stall_valid1", 64'(bus_a.valid), 64'h17);
        check_val("ex_stall_ena2", 64'(bus_a.ena), 64'h18);
        tick();
        check_val("ex_stall_valid2", 64'(bus_a.valid), 64'h07);
        check_val("ex_stall_cnt", bus_a.stall_cycles, 64'd2);
        check_val("ex_stall_retired", bus_a.retired, 64'd5);
        bus_a.stall_req = '0;
        tick();
        tick();
        check_val("refill_valid", 64'(bus_a.valid), 64'h1f);

        // Two simultaneous stalls: the higher one wins, counter +1
        bus_a.stall_req = 5'b01010;
        #1;
        check_val("prio_ena", 64'(bus_a.ena), 64'h10);
        tick();
        check_val("prio_valid", 64'(bus_a.valid), 64'h0f);
        check_val("prio_stall_cnt", bus_a.stall_cycles, 64'd3);
        check_val("prio_retired", bus_a.retired, 64'd6);

        // Flush with an IF stall: stall ignored, ID killed
        bus_a.stall_req = 5'b00001;
        bus_a.flush_req = 1'b1;
        #1;
        check_val("flush_ena", 64'(bus_a.ena), 64'h1f);
        tick();
        check_val("flush_valid", 64'(bus_a.valid), 64'h1d);
        check_val("flush_stall_cnt", bus_a.stall_cycles, 64'd3);

        // Flush with an EX stall: the stall wins
        bus_a.stall_req = 5'b00100;
        #1;
        check_val("flush_blk_ena", 64'(bus_a.ena), 64'h18);
        tick();
        check_val("flush_blk_valid", 64'(bus_a.valid), 64'h15);
        check_val("flush_blk_stall", bus_a.stall_cycles, 64'd4);
        check_val("flush_blk_retired", bus_a.retired, 64'd7);

        // Halt for three cycles, with a stall request that must not count
        bus_a.flush_req = 1'b0;
        bus_a.stall_req = 5'b00010;
        bus_a.halt      = 1'b1;
        #1;
        check_val("halt_ena", 64'(bus_a.ena), 64'h0);
        check_val("halt_retire", 64'(bus_a.retire), 64'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val($sformatf("halt_valid_%0d", k), 64'(bus_a.valid), 64'h15);
            check_val($sformatf("halt_stall_%0d", k), bus_a.stall_cycles, 64'd4);
            check_val($sformatf("halt_ret_%0d", k), bus_a.retired, 64'd7);
        end
        bus_a.halt      = 1'b0;
        bus_a.stall_req = '0;
        tick();
        check_val("unhalt_valid", 64'(bus_a.valid), 64'h0b);
        check_val("unhalt_retired", bus_a.retired, 64'd8);
        tick();
        check_val("pre_rst_valid", 64'(bus_a.valid), 64'h17);

        // Mid-run reset
        rst_a = 1'b1;
        #1;
        check_val("mid_rst_ena", 64'(bus_a.ena), 64'h0);
        check_val("mid_rst_retire", 64'(bus_a.retire), 64'h0);
        tick();
        check_val("mid_rst_valid", 64'(bus_a.valid), 64'h0);
        check_val("mid_rst_stall", bus_a.stall_cycles, 64'h0);
        check_val("mid_rst_retired", bus_a.retired, 64'h0);
        rst_a = 1'b0;

        // 4-bit counter wrap: after edge n (n >= 5), retired = n - 5
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        for (int n = 1; n <= 21; n++) begin
            tick();
        end
        check_val("wrap_16", 64'(bus_b.retired), 64'd0);
        tick();
        check_val("wrap_17", 64'(bus_b.retired), 64'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the in-order RV64 core. It replaces the fixed five-stage stall/valid controller. It tracks a registered per-stage valid bit and resolves multiple simultaneous stall requests by priority. It also kills wrong-path stages on a branch redirect, supports a global halt, and keeps stall-cycle and retired-instruction counters. It sits beside the stage registers and drives their load enables and valid inputs.

## Interface
Parameters:
- `STAGES`, 5: number of pipeline stages. Stage 0 is fetch; stage STAGES-1 is writeback. Legal range is 2..16.
- `FLUSH_STAGE`, 1: stage that resolves branches and raises `flush_req`. Legal range is 1..STAGES-2.
- `CNT_W`, 64: width of both performance counters.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `stall_req`, in, STAGES: bit i means stage i cannot complete this cycle.
- `flush_req`, in, 1: stage FLUSH_STAGE redirects fetch this cycle.
- `fetch_valid`, in, 1: the fetch unit presents a real instruction.
- `halt`, in, 1: freezes the whole pipeline, for ebreak or debug.
- `ena`, out, STAGES: load enable for stage register i. Combinational.
- `valid`, out, STAGES: stage i holds a real instruction. Registered.
- `retire`, out, 1: the instruction in the last stage completes this cycle.
- `stall_cycles`, out, CNT_W: count of cycles with an effective stall.
- `retired`, out, CNT_W: count of retired instructions.

## Operation
- **Hold point.** `hold` is the highest index i whose `stall_req[i]` is effective. If none is effective, `hold` = -1.
- **Effective stalls.** A stall request at a stage with index below FLUSH_STAGE is ignored when `flush_req` is effective. A stall request from a stage with `valid[i]`=0 is still honoured.
- **Effective flush.** `flush_req` is effective only when no stall is asserted at FLUSH_STAGE or above. When it is ineffective, it is dropped, and the source re-asserts it on a later cycle.
- **Load enables.** `ena[i]` = !halt && (i > hold).
- **Valid update** on a clock edge with `halt`=0:
  - i <= hold: `valid[i]` holds.
  - i == hold+1 and i >= 1: `valid[i]` <= 0, which inserts a bubble.
  - i > hold+1: `valid[i]` <= `valid[i-1]`.
  - i == 0 when advancing: `valid[0]` <= `fetch_valid`.
- **Flush.** When the flush is effective, stages 1..FLUSH_STAGE load 0 into their valid bits, because their inputs are wrong-path. Stage FLUSH_STAGE+1 still loads `valid[FLUSH_STAGE]`, which is the branch itself. Stage 0 loads `fetch_valid` from the redirected PC.
- **Halt.** When `halt`=1, all `ena` bits are 0, all `valid` bits hold, and both counters hold. Halt overrides stalls and flush.
- **Retire.** `retire` = `valid[STAGES-1]` && !halt && (hold != STAGES-1). A stall at the last stage blocks retire.
- **Counters.**
  - `stall_cycles` increments by 1 when `hold` >= 0 and `halt`=0.
  - `retired` increments by 1 when `retire`=1.
  - Both counters wrap modulo 2^CNT_W with no saturation.
- **Reset.** All `valid` bits go to 0 and both counters go to 0. During a cycle with `rst`=1, `ena` is all 0 and `retire`=0. In the first cycle after reset, `ena` follows the rules above.

## Timing
- `ena` and `retire` are combinational from `stall_req`, `flush_req`, `halt` and `valid`. There is no other internal state in that path.
- `valid` and both counters update on the rising edge of `clk`, with 1-cycle latency.
- A bubble inserted at stage hold+1 reaches the last stage after STAGES-2-hold further advancing cycles.
- Fill latency: after reset with `fetch_valid`=1 and no stalls, the first `retire` occurs in cycle STAGES counted from the first non-reset edge.
- `rst` asserted mid-operation discards all in-flight valids on the same edge. Counters clear on that edge.
- If `stall_req` and `flush_req` are asserted together with the stall at FLUSH_STAGE or above, the stall wins and the flush has no effect.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - stage index constants `STG_IF`=0, `STG_ID`=1, `STG_EX`=2, `STG_MEM`=3, `STG_WB`=4;
  - default `STAGES`=5;
  - the `CNT_W` default.
- Sub-module `pipe_ctrl_prio` is a parametrised highest-set-bit priority encoder. It outputs `hold` and a found flag, and is shared with the future multi-issue scoreboard.
- The top level owns the valid register vector, the flush and halt masking, and both counters.

## Test plan
- **Fill.** Release `rst` with `fetch_valid`=1 and no stalls. Required: `valid` goes 00001 → 00011 → … → 11111; `retire`=1 from cycle 5; `retired`=3 after 7 cycles.
- **Single stall.** Pulse `stall_req`=00100 (EX) for 2 cycles on a full pipe. Required: `ena`=11000 during both cycles; `valid[3]`=0 on the next edge; `stall_cycles`=2; no loss of IF/ID/EX contents.
- **Priority.** Assert `stall_req`=01010 for one cycle. Required: `ena`=10000; `valid[4]` <= 0; `stall_cycles` increments by 1, not 2.
- **Flush.** Assert `flush_req` with `stall_req`=00001. Required: the IF stall is ignored; `valid[1]` <= 0; `valid[2]` <= the prior `valid[1]`. Assert `flush_req` with `stall_req`=00100. Required: the flush is ignored; `ena`=11000.
- **Halt and reset.** Assert `halt` for 3 cycles. Required: `ena`=00000, `valid` frozen, counters frozen. Then assert `rst` for one cycle mid-run. Required: `valid`=00000, both counters 0, `retire`=0.
- **Wrap.** Run with `CNT_W`=4 and 17 retirements. Required: `retired`=1.
